apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB completer (slave) sitting on one `psel` bit driven by `ahb_apb_bridge`; the other end of the bridge's APB interface.
- Provides a DEPTH x 32-bit word-addressed register file.
- Inserts a configurable number of wait states via `pready`.
- Flags out-of-range or misaligned accesses with `pslverr`.

Parameters:
- `DEPTH`, 16, number of 32-bit words; power of two, range 2..256.
- `WAIT_STATES`, 0, extra ACCESS cycles before `pready` (0..15).
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.

Ports:
- `hclk`  in  1  clock, shared with bridge.
- `hresetn`  in  1  asynchronous active-low reset.
- `psel`  in  1  select for this completer.
- `penable`  in  1  APB access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  32  byte address.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data; valid when `pready` = 1.
- `pready`  out  1  transfer completes this cycle.
- `pslverr`  out  1  error response; valid only when `pready` = 1.

Behaviour:
- Reset: the asynchronous assert of `hresetn` forces the following. Deassertion is synchronous to `hclk`.
  - FSM = IDLE.
  - `pready` = 0, `pslverr` = 0, `prdata` = 0.
  - Wait counter = 0.
  - All storage words = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, WAIT, DONE (enum in package).
- IDLE:
  - `psel` & !`penable` -> SETUP.
  - On the same edge: capture `paddr`, `pwrite`, `pwdata`; load counter with `WAIT_STATES`.
  - `penable` seen in IDLE without a prior setup is ignored; stay in IDLE.
- SETUP (first ACCESS cycle, `penable` = 1 expected):
  - `WAIT_STATES` = 0 -> DONE: register `pready` = 1, `pslverr`, and `prdata`. The captured cycle already had `penable` = 1 at the decision point, so `pready` is seen in the 2nd ACCESS cycle.
  - Otherwise -> WAIT.
  - Minimum transfer = setup + 2 access cycles (1 registered-output latency).
- WAIT:
  - Counter decrements every cycle.
  - When counter == 1 -> DONE, with `pready` / `pslverr` / `prdata` registered.
  - Total ACCESS cycles = `WAIT_STATES` + 2.
- DONE (`pready` = 1 for exactly one cycle):
  - Writes commit to storage on the edge ending DONE, only if `pslverr` = 0.
  - Next state IDLE. If `psel` & !`penable` on that edge (back-to-back setup), go directly to SETUP and capture the new transfer.
- Error decode, computed at capture:
  - Conditions: `paddr[1:0]` != 0, OR `paddr` < `BASE_ADDR`, OR `paddr` >= `BASE_ADDR` + DEPTH*4.
  - Response: `pslverr` = 1, `prdata` = 0, no storage update.
- Word index = (`paddr` - `BASE_ADDR`)[log2(DEPTH)+1:2]; no wrap-around, because out-of-range accesses error.
- Read data: storage word at the index, sampled on entry to DONE. A write in a prior DONE is visible to the next read.
- `pready` low outside DONE. `prdata` and `pslverr` hold their last values but are only meaningful with `pready`.
- Abort: `psel` = 0 in SETUP or WAIT -> IDLE next edge. No write, no `pready`.
- Reset mid-transfer: immediate return to reset values; the pending write is dropped.

Optional Feature:
- Macro: `APB_SLV_RO_EN`.
- When defined:
  - Adds parameter `RO_MASK` (DEPTH bits, default all 0).
  - A write to a word whose `RO_MASK` bit = 1 completes with `pslverr` = 1 and does not change storage.
  - Reads of those words are unaffected.
- When undefined: all words are writable; no `RO_MASK` parameter or logic.

Decomposition:
- Package `apb_pkg`:
  - typedef enum logic [1:0] `apb_slv_state_t` {IDLE, SETUP, WAIT, DONE}.
  - Localparams `APB_ADDR_W` = 32, `APB_DATA_W` = 32.
  - Constant `APB_OKAY` = 1'b0, `APB_ERR` = 1'b1.
- Sub-module `apb_slave_regs`:
  - Storage array with async reset.
  - Inputs: one write port (`we`, `widx`, `wdata`) and one read index.
  - Output: read data.
- `apb_slave_mem` holds the FSM, capture registers, counter, and error decode.

Test Plan:
- Reset + idle: `hresetn` = 0 for 3 cycles, then idle bus. Required: `pready` = 0, `pslverr` = 0, `prdata` = 0. Reads of words 0..15 all return 0.
- `WAIT_STATES` = 0: write 32'hDEAD_BEEF to `paddr` 0x08, then read 0x08. Required: each transfer has `pready` in the 2nd access cycle; read returns 32'hDEAD_BEEF; `pslverr` = 0.
- `WAIT_STATES` = 3: read `paddr` 0x3C. Required: `pready` rises exactly 5 access cycles after setup, for one cycle.
- Errors:
  - Write 0x40 (DEPTH = 16) -> `pslverr` = 1, no storage change.
  - Read 0x06 -> `pslverr` = 1, `prdata` = 0.
  - A following read of 0x00 -> `pslverr` = 0.
- Back-to-back and abort:
  - Setup issued in the DONE cycle is captured with no IDLE gap.
  - Dropping `psel` during WAIT returns the FSM to IDLE, no write, no `pready`.
- `APB_SLV_RO_EN` with `RO_MASK` = 16'h0001: write 0x1234 to 0x00 -> `pslverr` = 1 and reads back 0. Write to 0x04 succeeds.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // pslverr encodings
  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    DONE
  } apb_slv_state_t;

endpackage

// File: rtl/apb_slave_regs.sv
// Word storage for the APB completer: one write port, one combinational read port.
// Latency: write lands on the clock edge with we=1; read data follows ridx combinationally.
// Backpressure: none, a write is accepted on every cycle that we is high.
//
// Ports: hclk/hresetn clock and async active-low reset (clears every word),
//        we/widx/wdata write port, ridx/rdata read port.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer exposing a DEPTH x 32-bit register file, optional read-only words (APB_SLV_RO_EN).
// Latency: pready in access cycle WAIT_STATES+2 after setup; all outputs registered.
// Backpressure: stretches ACCESS via pready; psel drop before DONE aborts with no write.
//
// Ports: hclk/hresetn clock and async active-low reset; psel/penable/pwrite/paddr/pwdata
//        APB request; prdata/pready/pslverr registered APB response.
// Reset deassertion is expected to be synchronised to hclk upstream.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int               DEPTH       = 16,
  parameter int               WAIT_STATES = 0,
  parameter logic [31:0]      BASE_ADDR   = 32'h0000_0000
`ifdef APB_SLV_RO_EN
  , parameter logic [DEPTH-1:0] RO_MASK   = '0
`endif
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IDX_W = $clog2(DEPTH);

  apb_slv_state_t state, nxt;

  logic                  cap_write;
  logic                  cap_err;
  logic [IDX_W-1:0]      cap_idx;
  logic [APB_DATA_W-1:0] cap_wdata;
  logic [3:0]            cnt;

  logic                  capture, cnt_dec, rsp_load, mem_we;
  logic [APB_DATA_W-1:0] rd_data;

  // Address decode. The offset is taken one bit wider so a borrow marks
  // "below base"; any offset bit above the index range marks "past the end".
  // BASE_ADDR is DEPTH*4 aligned, so offset[1:0] equals paddr[1:0].
  logic [APB_ADDR_W:0] off;
  logic [IDX_W-1:0]    addr_idx;
  logic                addr_err;
  logic                req_err;

  assign off      = {1'b0, paddr} - {1'b0, BASE_ADDR};
  assign addr_idx = off[IDX_W+1:2];
  assign addr_err = off[APB_ADDR_W] | (|off[APB_ADDR_W-1:IDX_W+2]) | (|off[1:0]);

`ifdef APB_SLV_RO_EN
  assign req_err = addr_err | (pwrite & RO_MASK[addr_idx]);
`else
  assign req_err = addr_err;
`endif

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (psel && !penable) nxt = SETUP;
      SETUP: begin
        if (!psel)                 nxt = IDLE;
        else if (WAIT_STATES == 0) nxt = DONE;
        else                       nxt = WAIT;
      end
      WAIT: begin
        if (!psel)            nxt = IDLE;
        else if (cnt == 4'd1) nxt = DONE;
      end
      DONE:    nxt = (psel && !penable) ? SETUP : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Control decode; entering SETUP from DONE is the back-to-back capture.
  always_comb begin
    capture  = (nxt == SETUP);
    cnt_dec  = (state == WAIT);
    rsp_load = (nxt == DONE);
    mem_we   = (state == DONE) && cap_write && !cap_err;
  end

  // Capture, wait counter and registered response
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cnt       <= '0;
      pready    <= 1'b0;
      pslverr   <= APB_OKAY;
      prdata    <= '0;
    end else begin
      if (capture) begin
        cap_write <= pwrite;
        cap_err   <= req_err;
        cap_idx   <= addr_idx;
        cap_wdata <= pwdata;
        cnt       <= 4'(WAIT_STATES);
      end else if (cnt_dec) begin
        cnt <= cnt - 4'd1;
      end
      pready <= rsp_load;
      if (rsp_load) begin
        pslverr <= cap_err ? APB_ERR : APB_OKAY;
        prdata  <= cap_err ? '0 : rd_data;
      end
    end
  end

  apb_slave_regs #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regs (
    .hclk    (hclk),
    .hresetn (hresetn),
    .we      (mem_we),
    .widx    (cap_idx),
    .wdata   (cap_wdata),
    .ridx    (cap_idx),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (no wait states at base 0, three wait
// states at base 0x100) driven by an APB master task, checked by a monitor
// against a word-array reference model through an expectation queue.
module tb_apb_slave_mem;

  localparam int          DEPTH = 16;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  logic        psel_a [2];
  logic        penable_a [2];
  logic        pwrite_a [2];
  logic [31:0] paddr_a [2];
  logic [31:0] pwdata_a [2];
  logic [31:0] prdata_a [2];
  logic        pready_a [2];
  logic        pslverr_a [2];

  always #5 hclk = ~hclk;

  apb_slave_mem #(
    .DEPTH(DEPTH), .WAIT_STATES(WS0), .BASE_ADDR(BASE0)
`ifdef APB_SLV_RO_EN
    , .RO_MASK(16'h0001)
`endif
  ) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel_a[0]), .penable(penable_a[0]),
    .pwrite(pwrite_a[0]), .paddr(paddr_a[0]), .pwdata(pwdata_a[0]),
    .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0])
  );

  apb_slave_mem #(
    .DEPTH(DEPTH), .WAIT_STATES(WS1), .BASE_ADDR(BASE1)
  ) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel_a[1]), .penable(penable_a[1]),
    .pwrite(pwrite_a[1]), .paddr(paddr_a[1]), .pwdata(pwdata_a[1]),
    .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1])
  );

  typedef struct {
    int          dut;
    bit          wr;
    bit          err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mdl [2][DEPTH];
  int          tot = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_setup [2];
  bit          prev_rdy [2];

  always @(posedge hclk) cyc++;

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a transfer errors if misaligned or outside
  // [base, base + DEPTH*4); good writes update the word array, good reads return it.
  task automatic predict(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t   e;
    longint off;
    int     idx;
    off     = longint'({32'h0, addr}) - longint'({32'h0, base_of(d)});
    e.dut   = d;
    e.wr    = wr;
    e.lat   = ws_of(d) + 2;
    e.err   = (addr % 4 != 0) || (off < 0) || (off >= DEPTH * 4);
    e.rdata = 32'h0;
    idx     = e.err ? 0 : int'(off / 4);
`ifdef APB_SLV_RO_EN
    if (!e.err && wr && d == 0 && idx == 0) e.err = 1'b1;
`endif
    if (!e.err) begin
      if (wr) mdl[d][idx] = data;
      else    e.rdata = mdl[d][idx];
    end
    exp_q.push_back(e);
  endtask

  // Full transfer; returns #1 after the edge that raised pready (the DONE cycle),
  // so calling it again immediately issues a back-to-back setup.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int n;
    predict(d, wr, addr, data);
    psel_a[d] = 1'b1; penable_a[d] = 1'b0; pwrite_a[d] = wr;
    paddr_a[d] = addr; pwdata_a[d] = data;
    @(posedge hclk); #1;
    penable_a[d] = 1'b1;
    n = 0;
    do begin
      @(posedge hclk); #1;
      n++;
    end while (!pready_a[d] && n < 40);
    if (!pready_a[d]) begin
      tot++; bad++;
      $display("FAIL xfer_timeout dut%0d addr %h: no pready within %0d cycles", d, addr, n);
      void'(exp_q.pop_back());
      psel_a[d] = 1'b0; penable_a[d] = 1'b0;
    end
  endtask

  task automatic bus_idle(input int d);
    @(posedge hclk); #1;
    psel_a[d] = 1'b0; penable_a[d] = 1'b0;
  endtask

  // Setup followed by n access cycles, then psel drops: no response expected.
  task automatic abort_xfer(input int d, input logic [31:0] addr, input logic [31:0] data, input int n);
    psel_a[d] = 1'b1; penable_a[d] = 1'b0; pwrite_a[d] = 1'b1;
    paddr_a[d] = addr; pwdata_a[d] = data;
    @(posedge hclk); #1;
    repeat (n) begin
      penable_a[d] = 1'b1;
      @(posedge hclk); #1;
    end
    psel_a[d] = 1'b0; penable_a[d] = 1'b0;
    repeat (3) begin
      @(posedge hclk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int          k;
    logic [31:0] b;
    k = $urandom_range(0, 9);
    b = base_of(d);
    if (k <= 5)      return b + 32'($urandom_range(0, DEPTH - 1) * 4);
    else if (k == 6) return b + 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    else if (k == 7) return b + 32'(DEPTH * 4 + $urandom_range(0, 200) * 4);
    else if (k == 8 && d == 1) return 32'($urandom_range(0, 63) * 4);
    else             return ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
  endfunction

  // Monitor: every pready pops one expectation and checks it.
  always @(negedge hclk) begin
    for (int d = 0; d < 2; d++) begin
      if (!hresetn) begin
        prev_rdy[d] = 1'b0;
      end else begin
        if (pready_a[d]) begin
          if (prev_rdy[d]) begin
            tot++; bad++;
            $display("FAIL pready_width dut%0d: high two cycles running, want one", d);
          end
          if (exp_q.size() == 0) begin
            tot++; bad++;
            $display("FAIL unexpected_pready dut%0d: pready with nothing outstanding", d);
          end else begin
            mon_e = exp_q.pop_front();
            check("dut_id", 32'(d), 32'(mon_e.dut));
            check("latency", 32'(cyc - last_setup[d]), 32'(mon_e.lat));
            check("pslverr", {31'b0, pslverr_a[d]}, {31'b0, mon_e.err});
            if (!mon_e.wr) check("prdata", prdata_a[d], mon_e.rdata);
          end
        end
        if (psel_a[d] && !penable_a[d]) last_setup[d] = cyc;
        prev_rdy[d] = pready_a[d];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    int d;
    for (int i = 0; i < 2; i++) begin
      psel_a[i] = 1'b0; penable_a[i] = 1'b0; pwrite_a[i] = 1'b0;
      paddr_a[i] = '0; pwdata_a[i] = '0;
      last_setup[i] = 0; prev_rdy[i] = 1'b0;
      for (int j = 0; j < DEPTH; j++) mdl[i][j] = '0;
    end

    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(negedge hclk);
    for (int i = 0; i < 2; i++) begin
      check("rst_pready", {31'b0, pready_a[i]}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr_a[i]}, 32'h0);
      check("rst_prdata", prdata_a[i], 32'h0);
    end
    @(posedge hclk); #1;

    for (int i = 0; i < DEPTH; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0); bus_idle(0);
    end

    xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF); bus_idle(0);
    xfer(0, 1'b0, 32'h08, 32'h0);         bus_idle(0);

    xfer(1, 1'b0, 32'h3C, 32'h0);  bus_idle(1);
    xfer(1, 1'b0, 32'h13C, 32'h0); bus_idle(1);

    xfer(0, 1'b1, 32'h40, 32'hA5A5_A5A5); bus_idle(0);
    xfer(0, 1'b0, 32'h06, 32'h0);         bus_idle(0);
    xfer(0, 1'b0, 32'h00, 32'h0);         bus_idle(0);

    xfer(0, 1'b1, 32'h10, 32'h1122_3344);
    xfer(0, 1'b0, 32'h10, 32'h0);
    xfer(0, 1'b1, 32'h14, 32'h0000_0055);
    xfer(0, 1'b0, 32'h14, 32'h0);
    bus_idle(0);
    xfer(1, 1'b1, 32'h104, 32'h0BAD_F00D);
    xfer(1, 1'b0, 32'h104, 32'h0);
    bus_idle(1);

    abort_xfer(1, 32'h120, 32'hBAD0_BAD0, 2);
    xfer(1, 1'b0, 32'h120, 32'h0); bus_idle(1);
    abort_xfer(0, 32'h20, 32'hBAD1_BAD1, 0);
    xfer(0, 1'b0, 32'h20, 32'h0);  bus_idle(0);

    xfer(0, 1'b1, 32'h00, 32'h0000_1234); bus_idle(0);
    xfer(0, 1'b0, 32'h00, 32'h0);         bus_idle(0);
    xfer(0, 1'b1, 32'h04, 32'h0000_5678); bus_idle(0);
    xfer(0, 1'b0, 32'h04, 32'h0);         bus_idle(0);

    for (int b = 0; b < 12; b++) begin
      d = int'($urandom_range(0, 1));
      pend = 1'b0;
      for (int k = 0; k < 10; k++) begin
        xfer(d, 1'($urandom_range(0, 1)), rand_addr(d), $urandom);
        pend = ($urandom_range(0, 2) == 0);
        if (!pend) bus_idle(d);
      end
      if (pend) bus_idle(d);
    end

    // Reset in the middle of a write: storage clears, the pending write is lost.
    xfer(1, 1'b1, 32'h11C, 32'hCAFE_0001); bus_idle(1);
    psel_a[1] = 1'b1; penable_a[1] = 1'b0; pwrite_a[1] = 1'b1;
    paddr_a[1] = 32'h11C; pwdata_a[1] = 32'hCAFE_0002;
    @(posedge hclk); #1;
    penable_a[1] = 1'b1;
    @(posedge hclk); #1;
    hresetn = 1'b0;
    psel_a[1] = 1'b0; penable_a[1] = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) mdl[i][j] = '0;
    @(negedge hclk);
    check("midrst_pready", {31'b0, pready_a[1]}, 32'h0);
    check("midrst_prdata", prdata_a[0], 32'h0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(posedge hclk); #1;
    xfer(1, 1'b0, 32'h11C, 32'h0); bus_idle(1);
    xfer(0, 1'b0, 32'h08, 32'h0);  bus_idle(0);

    repeat (5) @(posedge hclk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
